// File: rtl/reset_seq_pkg.sv
// Shared types and width helpers for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  function automatic int cnt_width(input int stage_delay, input int lock_timeout);
    int m;
    m = (stage_delay > lock_timeout) ? stage_delay : lock_timeout;
    return $clog2(m + 1);
  endfunction

  function automatic int idx_width(input int num_stages);
    return (num_stages > 1) ? $clog2(num_stages) : 1;
  endfunction

  function automatic int retry_width(input int max_retry);
    return (max_retry > 0) ? $clog2(max_retry + 1) : 1;
  endfunction

endpackage

// File: rtl/reset_seq_hsync_bit.sv
// 2-FF single-bit synchronizer, async active-high reset to 0.
module hsync_bit (
  input  logic Clock,
  input  logic qReset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge Clock or posedge qReset) begin
    if (qReset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/reset_seq.sv
// Post-synchronizer reset sequencer: PLL reset hold, lock wait with retries, staged release.
// Build option RESET_SEQ_LOCK_MON_EN: lock loss in RUN restarts the sequence.
//
// state     | meaning
// PLL_RST   | PLL held in reset for STAGE_DELAY cycles
// WAIT_LOCK | waiting for synchronized lock, LOCK_TIMEOUT budget
// RELEASE   | stages released one per STAGE_DELAY slot
// RUN       | all stages released
// FAULT     | retries exhausted, everything held in reset
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES   = 4,
  parameter int STAGE_DELAY  = 16,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int MAX_RETRY    = 3
) (
  input  logic                              Clock,
  input  logic                              qReset,
  input  logic                              iPllLock,
  input  logic                              iSoftReset,
  output logic                              oPllReset,
  output logic [NUM_STAGES-1:0]             oStageReset,
  output logic                              oDone,
  output logic                              oFault,
  output logic [retry_width(MAX_RETRY)-1:0] oRetryCnt
);

  localparam int CW = cnt_width(STAGE_DELAY, LOCK_TIMEOUT);
  localparam int IW = idx_width(NUM_STAGES);
  localparam int RW = retry_width(MAX_RETRY);

  localparam logic [CW-1:0] SLOT_LAST    = CW'(STAGE_DELAY - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [IW-1:0] STAGE_LAST   = IW'(NUM_STAGES - 1);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRY);

  logic                  w_lock;
  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [RW-1:0]         r_retry;
  logic                  r_pll_rst;
  logic [NUM_STAGES-1:0] r_stage_rst;
  logic                  r_done;
  logic                  r_fault;

  hsync_bit u_lock_sync (
    .Clock  (Clock),
    .qReset (qReset),
    .i_d    (iPllLock),
    .o_q    (w_lock)
  );

  always_ff @(posedge Clock or posedge qReset) begin
    if (qReset) begin
      r_state     <= PLL_RST;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_retry     <= '0;
      r_pll_rst   <= 1'b1;
      r_stage_rst <= '1;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
    end else if (iSoftReset) begin
      r_state     <= PLL_RST;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_retry     <= '0;
      r_pll_rst   <= 1'b1;
      r_stage_rst <= '1;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      case (r_state)
        PLL_RST: begin
          if (r_cnt == SLOT_LAST) begin
            r_state   <= WAIT_LOCK;
            r_pll_rst <= 1'b0;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        WAIT_LOCK: begin
          if (w_lock) begin
            r_state <= RELEASE;
            r_cnt   <= '0;
            r_idx   <= '0;
          end else if (r_cnt == TIMEOUT_LAST) begin
            r_cnt     <= '0;
            r_pll_rst <= 1'b1;
            if (r_retry == RETRY_MAX) begin
              r_state <= FAULT;
              r_fault <= 1'b1;
            end else begin
              r_state <= PLL_RST;
              r_retry <= r_retry + RW'(1);
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RELEASE: begin
          if (!w_lock) begin
            r_state     <= PLL_RST;
            r_pll_rst   <= 1'b1;
            r_stage_rst <= '1;
            r_cnt       <= '0;
            r_idx       <= '0;
          end else if (r_cnt == SLOT_LAST) begin
            r_cnt       <= '0;
            r_stage_rst <= r_stage_rst & ~(NUM_STAGES'(1) << r_idx);
            if (r_idx == STAGE_LAST) begin
              r_state <= RUN;
              r_done  <= 1'b1;
              r_retry <= '0;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RUN: begin
`ifdef RESET_SEQ_LOCK_MON_EN
          if (!w_lock) begin
            r_state     <= PLL_RST;
            r_pll_rst   <= 1'b1;
            r_stage_rst <= '1;
            r_done      <= 1'b0;
            r_cnt       <= '0;
            r_idx       <= '0;
          end
`else
          r_done <= 1'b1;
`endif
        end
        FAULT: begin
          r_pll_rst   <= 1'b1;
          r_stage_rst <= '1;
          r_fault     <= 1'b1;
        end
        default: begin
          r_state     <= PLL_RST;
          r_cnt       <= '0;
          r_idx       <= '0;
          r_pll_rst   <= 1'b1;
          r_stage_rst <= '1;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  assign oPllReset   = r_pll_rst;
  assign oStageReset = r_stage_rst;
  assign oDone       = r_done;
  assign oFault      = r_fault;
  assign oRetryCnt   = r_retry;

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq (NUM_STAGES=3, STAGE_DELAY=4, LOCK_TIMEOUT=20, MAX_RETRY=2).
module tb_reset_seq;

  logic       Clock = 1'b0;
  logic       qReset = 1'b1;
  logic       iPllLock = 1'b0;
  logic       iSoftReset = 1'b0;
  logic       oPllReset;
  logic [2:0] oStageReset;
  logic       oDone;
  logic       oFault;
  logic [1:0] oRetryCnt;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int base = 0;

  reset_seq #(
    .NUM_STAGES   (3),
    .STAGE_DELAY  (4),
    .LOCK_TIMEOUT (20),
    .MAX_RETRY    (2)
  ) dut (
    .Clock       (Clock),
    .qReset      (qReset),
    .iPllLock    (iPllLock),
    .iSoftReset  (iSoftReset),
    .oPllReset   (oPllReset),
    .oStageReset (oStageReset),
    .oDone       (oDone),
    .oFault      (oFault),
    .oRetryCnt   (oRetryCnt)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, cyc - base);
    end
  endtask

  task automatic at_edge(input int n);
    while (cyc - base < n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic do_reset(input logic lock);
    @(posedge Clock);
    #1;
    qReset   = 1'b1;
    iPllLock = lock;
    iSoftReset = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    chk("rst_pll",   32'(oPllReset),   32'd1);
    chk("rst_stage", 32'(oStageReset), 32'd7);
    chk("rst_done",  32'(oDone),       32'd0);
    chk("rst_fault", 32'(oFault),      32'd0);
    chk("rst_retry", 32'(oRetryCnt),   32'd0);
    qReset = 1'b0;
    base   = cyc;
  endtask

  initial begin
    // Nominal sequence, lock high throughout
    do_reset(1'b1);
    at_edge(3);  chk("nom_pll_e3",    32'(oPllReset), 32'd1);
    at_edge(4);  chk("nom_pll_e4",    32'(oPllReset), 32'd0);
    at_edge(8);  chk("nom_stage_e8",  32'(oStageReset), 32'd7);
    at_edge(9);  chk("nom_stage_e9",  32'(oStageReset), 32'd6);
    at_edge(12); chk("nom_stage_e12", 32'(oStageReset), 32'd6);
    at_edge(13); chk("nom_stage_e13", 32'(oStageReset), 32'd4);
    at_edge(16); chk("nom_done_e16",  32'(oDone), 32'd0);
    at_edge(17); chk("nom_stage_e17", 32'(oStageReset), 32'd0);
                 chk("nom_done_e17",  32'(oDone), 32'd1);
    at_edge(25); chk("run_retry",     32'(oRetryCnt), 32'd0);
                 chk("run_done",      32'(oDone), 32'd1);
    iPllLock = 1'b0;
    at_edge(30);
`ifdef RESET_SEQ_LOCK_MON_EN
    chk("mon_done",  32'(oDone), 32'd0);
    chk("mon_stage", 32'(oStageReset), 32'd7);
    chk("mon_pll",   32'(oPllReset), 32'd1);
`else
    chk("nomon_done",  32'(oDone), 32'd1);
    chk("nomon_stage", 32'(oStageReset), 32'd0);
    chk("nomon_pll",   32'(oPllReset), 32'd0);
`endif

    // Lock loss mid-RELEASE
    do_reset(1'b1);
    at_edge(11); iPllLock = 1'b0;
    at_edge(13); chk("loss_stage_e13", 32'(oStageReset), 32'd4);
    at_edge(14); chk("loss_stage_e14", 32'(oStageReset), 32'd7);
                 chk("loss_pll_e14",   32'(oPllReset), 32'd1);
                 chk("loss_retry",     32'(oRetryCnt), 32'd0);
    at_edge(17); chk("loss_pll_e17",   32'(oPllReset), 32'd1);
    at_edge(18); chk("loss_pll_e18",   32'(oPllReset), 32'd0);

    // Lock never arrives: two retries then fault, then soft reset, then async reset
    do_reset(1'b0);
    at_edge(23); chk("to_retry_e23", 32'(oRetryCnt), 32'd0);
                 chk("to_pll_e23",   32'(oPllReset), 32'd0);
    at_edge(24); chk("to_retry_e24", 32'(oRetryCnt), 32'd1);
                 chk("to_pll_e24",   32'(oPllReset), 32'd1);
    at_edge(28); chk("to_pll_e28",   32'(oPllReset), 32'd0);
    at_edge(48); chk("to_retry_e48", 32'(oRetryCnt), 32'd2);
                 chk("to_pll_e48",   32'(oPllReset), 32'd1);
    at_edge(71); chk("to_fault_e71", 32'(oFault), 32'd0);
    at_edge(72); chk("to_fault_e72", 32'(oFault), 32'd1);
                 chk("to_pll_e72",   32'(oPllReset), 32'd1);
                 chk("to_stage_e72", 32'(oStageReset), 32'd7);
    at_edge(80); chk("to_fault_e80", 32'(oFault), 32'd1);
                 chk("to_retry_e80", 32'(oRetryCnt), 32'd2);
    iSoftReset = 1'b1;
    iPllLock   = 1'b1;
    at_edge(81); iSoftReset = 1'b0;
                 chk("sr_fault", 32'(oFault), 32'd0);
                 chk("sr_retry", 32'(oRetryCnt), 32'd0);
                 chk("sr_pll",   32'(oPllReset), 32'd1);
                 chk("sr_stage", 32'(oStageReset), 32'd7);
    at_edge(85); chk("sr_pll_e85",   32'(oPllReset), 32'd0);
    at_edge(89); chk("sr_stage_e89", 32'(oStageReset), 32'd7);
    at_edge(90); chk("sr_stage_e90", 32'(oStageReset), 32'd6);
    at_edge(95); chk("sr_stage_e95", 32'(oStageReset), 32'd4);
    #2;
    qReset = 1'b1;
    #1;
    chk("async_pll",   32'(oPllReset), 32'd1);
    chk("async_stage", 32'(oStageReset), 32'd7);
    chk("async_done",  32'(oDone), 32'd0);
    chk("async_retry", 32'(oRetryCnt), 32'd0);

    // Lock arrives during the second attempt
    do_reset(1'b0);
    at_edge(24); chk("late_retry_e24", 32'(oRetryCnt), 32'd1);
    at_edge(30); iPllLock = 1'b1;
    at_edge(36); chk("late_stage_e36", 32'(oStageReset), 32'd7);
    at_edge(37); chk("late_stage_e37", 32'(oStageReset), 32'd6);
    at_edge(44); chk("late_stage_e44", 32'(oStageReset), 32'd4);
                 chk("late_retry_e44", 32'(oRetryCnt), 32'd1);
    at_edge(45); chk("late_stage_e45", 32'(oStageReset), 32'd0);
                 chk("late_done_e45",  32'(oDone), 32'd1);
                 chk("late_retry_e45", 32'(oRetryCnt), 32'd0);
                 chk("late_fault_e45", 32'(oFault), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/reset_seq.md
# reset_seq

Post-synchronizer reset sequencer. Consumes a synchronized reset, holds the PLL in reset for a programmed time, then waits for lock with a timeout and bounded retries. After lock, releases a chain of downstream reset domains one at a time in fixed order. Sits directly after the per-clock-domain reset synchronizer and drives the PLL and the datapath block resets of that domain.

## Interface
Parameters:
- NUM_STAGES, 4, number of sequenced stage resets (≥1)
- STAGE_DELAY, 16, cycles per PLL-reset hold and per stage-release slot (≥2)
- LOCK_TIMEOUT, 1024, cycles allowed in lock wait before a retry (≥2)
- MAX_RETRY, 3, lock-timeout retries before fault (≥0)

Ports:
- Clock  input  1  domain clock
- qReset  input  1  reset, asynchronous, active-high; already synchronously deasserted by the upstream synchronizer
- iPllLock  input  1  PLL lock; asynchronous to Clock
- iSoftReset  input  1  synchronous restart request, sampled every cycle
- oPllReset  output  1  PLL reset, active-high, registered
- oStageReset  output  NUM_STAGES  stage resets, active-high, registered; bit 0 released first
- oDone  output  1  all stages released
- oFault  output  1  retries exhausted
- oRetryCnt  output  $clog2(MAX_RETRY+1) (min 1)  timeouts in the current attempt sequence

## Operation
- Reset values (qReset high): state PLL_RST, oPllReset=1, oStageReset=all 1, oDone=0, oFault=0, oRetryCnt=0, counters 0.
- iPllLock passes through a 2-FF synchronizer. The sync FFs also reset to 0 on qReset. The FSM uses only the synchronized lock.
- PLL_RST: oPllReset=1. Stay STAGE_DELAY cycles, then go to WAIT_LOCK. oPllReset=0 on the transition edge.
- WAIT_LOCK:
  - Synchronized lock=1 → RELEASE.
  - LOCK_TIMEOUT cycles without lock and oRetryCnt<MAX_RETRY → oRetryCnt+1, then PLL_RST (oPllReset=1 on that edge).
  - Timeout with oRetryCnt==MAX_RETRY → FAULT.
- RELEASE: stage k releases (oStageReset[k]→0) exactly (k+1)*STAGE_DELAY cycles after the WAIT_LOCK→RELEASE edge. After stage NUM_STAGES-1 releases, go to RUN. oDone=1 on that same edge.
- RUN: hold all resets low, oDone=1, oRetryCnt=0.
- FAULT: oPllReset=1, all stage resets 1, oFault=1. Exit only via qReset or iSoftReset.
- Lock loss (synchronized lock=0) in RELEASE:
  - Next edge: all stage resets to 1 and state to PLL_RST.
  - oRetryCnt unchanged.
- iSoftReset=1 in any state, highest priority:
  - Next edge: state PLL_RST, all resets 1, oDone=0, oFault=0, oRetryCnt=0, counters cleared.
- Priority: iSoftReset > lock loss > timeout > normal progression.
- Counters saturate and never wrap. Slot and timeout counters are cleared on every state entry.

## Timing
- Edge numbering: edge n is the n-th rising Clock edge after qReset falls.
- oPllReset falls at edge STAGE_DELAY.
- Lock detect latency: 2 sync cycles, plus 1 cycle to the state transition.
- Stage release edges are defined relative to the RELEASE entry edge, as given under Operation.
- All outputs are registered. No combinational path from any input to any output.
- qReset asserted mid-sequence: all outputs return to reset values asynchronously.

## Configuration
- RESET_SEQ_LOCK_MON_EN defined: lock loss in RUN is treated like lock loss in RELEASE.
  - oDone→0, all stage resets→1, state→PLL_RST.
  - oRetryCnt unchanged.
- Not defined: lock is ignored in RUN. Once RUN is reached, only qReset or iSoftReset restarts the sequence.

## Structure
- reset_seq_pkg holds:
  - state encodings PLL_RST, WAIT_LOCK, RELEASE, RUN, FAULT (3-bit)
  - the counter-width function (clog2 of max(STAGE_DELAY, LOCK_TIMEOUT)+1)
  - the stage-index width
- One sub-module, hsync_bit: 2-FF single-bit synchronizer with async active-high reset to 0, used for iPllLock.

## Test plan
Common settings: NUM_STAGES=3, STAGE_DELAY=4, LOCK_TIMEOUT=20, MAX_RETRY=2.
- iPllLock high throughout, release qReset → oPllReset falls edge 4; RELEASE entered edge 5; oStageReset[0/1/2] fall at edges 9/13/17; oDone=1 at edge 17.
- iPllLock held low → timeouts at edges 24 and 48 (oRetryCnt 1, 2; oPllReset re-rises at each); at edge 72 oFault=1 and all resets high.
- iPllLock rises at edge 30, in the second attempt → RELEASE follows 3 edges later. The sequence completes with oRetryCnt=1 until RUN, then 0.
- Drop iPllLock at edge 11 (mid-RELEASE) → all oStageReset high within 3 edges, state PLL_RST, oRetryCnt unchanged.
- In RUN, drop iPllLock:
  - With RESET_SEQ_LOCK_MON_EN → oDone=0, resets reassert.
  - Without → outputs unchanged.
- Pulse iSoftReset in FAULT, then assert qReset at edge 14 → soft reset clears oFault and restarts the full sequence; qReset forces reset values immediately, without waiting for a clock edge.
